// File: rtl/mem_lsu_if.sv
// Core-side request/response and memory-side bus of the load/store unit.
// The master modport is the LSU view; slave is the core plus memory view.
interface mem_lsu_if;
   logic        req;
   logic        is_store;
   logic        is_byte;
   logic        sign_ext;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic        busy;
   logic        done;
   logic [15:0] rdata;
   logic [15:0] addrm;
   logic [15:0] wmdata;
   logic        we;
   logic        mem_alu;
   logic [15:0] rmdata;

   modport master (
      input  req, is_store, is_byte, sign_ext, addr, wdata, rmdata,
      output busy, done, rdata, addrm, wmdata, we, mem_alu
   );

   modport slave (
      output req, is_store, is_byte, sign_ext, addr, wdata, rmdata,
      input  busy, done, rdata, addrm, wmdata, we, mem_alu
   );
endinterface

// File: rtl/mem_lsu.sv
// Load/store initiator: splits byte and unaligned word accesses into aligned
// read / read-modify-write cycles against a 16-bit, byte-addressed memory.
module mem_lsu #(
   parameter int AW = 16,
   parameter int DW = 16
) (
   input logic       clock,
   input logic       reset,
   mem_lsu_if.master bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_LO = 3'd1,
      WR_LO = 3'd2,
      RD_HI = 3'd3,
      WR_HI = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t          state_r;
   state_t          state_nx_s;
   logic [AW-1:0]   addr_r;
   logic [DW-1:0]   wdata_r;
   logic [DW-1:0]   buf_r;
   logic [DW-1:0]   rdata_r;
   logic [7:0]      lo_r;
   logic            store_r;
   logic            byte_r;
   logic            sext_r;

   logic [AW-1:0]   base_lo_s;
   logic [AW-1:0]   base_hi_s;
   logic            odd_s;
   logic [7:0]      rd_byte_s;
   logic [DW-1:0]   ext_byte_s;
   logic [AW-1:0]   addrm_s;
   logic [DW-1:0]   wmdata_s;
   logic            we_s;
   logic            mem_alu_s;

   assign odd_s     = addr_r[0];
   assign base_lo_s = {addr_r[AW-1:1], 1'b0};
   assign base_hi_s = base_lo_s + 16'd2;

   // Select and extend the addressed byte of the current read word.
   always_comb begin
      rd_byte_s  = 8'h00;
      ext_byte_s = 16'h0000;
      if (odd_s) begin
         rd_byte_s = bus.rmdata[15:8];
      end else begin
         rd_byte_s = bus.rmdata[7:0];
      end
      if (sext_r) begin
         ext_byte_s = {{8{rd_byte_s[7]}}, rd_byte_s};
      end else begin
         ext_byte_s = {8'h00, rd_byte_s};
      end
   end

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state sequencing of the access steps.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.req) begin
               if (bus.is_store && !bus.is_byte && !bus.addr[0]) begin
                  state_nx_s = WR_LO;
               end else begin
                  state_nx_s = RD_LO;
               end
            end else begin
               state_nx_s = IDLE;
            end
         end
         RD_LO: begin
            if (store_r) begin
               state_nx_s = WR_LO;
            end else if (!byte_r && odd_s) begin
               state_nx_s = RD_HI;
            end else begin
               state_nx_s = DONE;
            end
         end
         WR_LO: begin
            if (!byte_r && odd_s) begin
               state_nx_s = RD_HI;
            end else begin
               state_nx_s = DONE;
            end
         end
         RD_HI: begin
            if (store_r) begin
               state_nx_s = WR_HI;
            end else begin
               state_nx_s = DONE;
            end
         end
         WR_HI:   state_nx_s = DONE;
         DONE:    state_nx_s = IDLE;
         default: state_nx_s = IDLE;
      endcase
   end

   // Request capture and read-data handling.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         addr_r  <= 16'h0000;
         wdata_r <= 16'h0000;
         buf_r   <= 16'h0000;
         rdata_r <= 16'h0000;
         lo_r    <= 8'h00;
         store_r <= 1'b0;
         byte_r  <= 1'b0;
         sext_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.req) begin
                  addr_r  <= bus.addr;
                  wdata_r <= bus.wdata;
                  store_r <= bus.is_store;
                  byte_r  <= bus.is_byte;
                  sext_r  <= bus.sign_ext;
               end
            end
            RD_LO: begin
               if (store_r) begin
                  buf_r <= bus.rmdata;
               end else if (byte_r) begin
                  rdata_r <= ext_byte_s;
               end else if (odd_s) begin
                  lo_r <= bus.rmdata[15:8];
               end else begin
                  rdata_r <= bus.rmdata;
               end
            end
            RD_HI: begin
               if (store_r) begin
                  buf_r <= bus.rmdata;
               end else begin
                  rdata_r <= {bus.rmdata[7:0], lo_r};
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Memory-side decode; untouched bytes are rewritten from the word just read.
   always_comb begin
      addrm_s   = 16'h0000;
      wmdata_s  = 16'h0000;
      we_s      = 1'b0;
      mem_alu_s = 1'b0;
      case (state_r)
         RD_LO: begin
            addrm_s   = base_lo_s;
            mem_alu_s = 1'b1;
         end
         WR_LO: begin
            addrm_s   = base_lo_s;
            mem_alu_s = 1'b1;
            we_s      = 1'b1;
            if (!byte_r && !odd_s) begin
               wmdata_s = wdata_r;
            end else if (byte_r && !odd_s) begin
               wmdata_s = {buf_r[15:8], wdata_r[7:0]};
            end else begin
               wmdata_s = {wdata_r[7:0], buf_r[7:0]};
            end
         end
         RD_HI: begin
            addrm_s   = base_hi_s;
            mem_alu_s = 1'b1;
         end
         WR_HI: begin
            addrm_s   = base_hi_s;
            mem_alu_s = 1'b1;
            we_s      = 1'b1;
            wmdata_s  = {buf_r[15:8], wdata_r[15:8]};
         end
         default: begin
            addrm_s = 16'h0000;
         end
      endcase
   end

   assign bus.addrm   = addrm_s;
   assign bus.wmdata  = wmdata_s;
   assign bus.we      = we_s;
   assign bus.mem_alu = mem_alu_s;
   assign bus.busy    = (state_r != IDLE);
   assign bus.done    = (state_r == DONE);
   assign bus.rdata   = rdata_r;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed scenarios plus randomized loads/stores checked
// against a byte-array reference memory.
module tb_mem_lsu;

   logic clock = 1'b0;
   logic reset = 1'b1;

   mem_lsu_if bus ();

   mem_lsu dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   logic [7:0]  mem     [0:65535];
   logic [7:0]  ref_mem [0:65535];
   logic        pl_en = 1'b0;
   logic [15:0] pl_addr = 16'h0000;
   logic [7:0]  pl_data = 8'h00;

   int          checks = 0;
   int          failures = 0;
   logic [15:0] seq_a [0:7];
   logic [15:0] seq_w [0:7];
   int          seq_n, we_cnt, lat, busy_bad, odd_cnt, done_cnt;
   logic [15:0] rdata_exp = 16'h0000;

   always #5 clock = ~clock;

   assign bus.rmdata = {mem[{bus.addrm[15:1], 1'b1}], mem[{bus.addrm[15:1], 1'b0}]};

   always @(posedge clock) begin
      if (bus.we) begin
         mem[{bus.addrm[15:1], 1'b0}] <= bus.wmdata[7:0];
         mem[{bus.addrm[15:1], 1'b1}] <= bus.wmdata[15:8];
      end else if (pl_en) begin
         mem[pl_addr] <= pl_data;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [15:0] a, input logic [7:0] d);
      @(negedge clock);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      ref_mem[a] = d;
      @(negedge clock);
      pl_en = 1'b0;
   endtask

   task automatic run_op(input logic st, input logic by, input logic se,
                         input logic [15:0] a, input logic [15:0] wd, input bit noise);
      @(negedge clock);
      bus.req = 1'b1; bus.is_store = st; bus.is_byte = by; bus.sign_ext = se;
      bus.addr = a; bus.wdata = wd;
      @(negedge clock);
      bus.req = 1'b0;
      bus.addr = 16'($urandom); bus.wdata = 16'($urandom);
      bus.is_store = 1'($urandom); bus.is_byte = 1'($urandom); bus.sign_ext = 1'($urandom);
      seq_n = 0; we_cnt = 0; lat = -1; busy_bad = 0; odd_cnt = 0;
      for (int c = 1; c <= 8; c++) begin
         if (c > 1) @(negedge clock);
         if (!bus.busy) busy_bad++;
         if (bus.mem_alu && seq_n < 8) begin
            seq_a[seq_n] = bus.addrm;
            seq_w[seq_n] = bus.wmdata;
            seq_n++;
            if (bus.addrm[0]) odd_cnt++;
         end
         if (bus.we) we_cnt++;
         if (bus.done) begin
            lat = c;
            break;
         end
         if (noise) bus.req = 1'($urandom);
      end
      bus.req = 1'b0;
   endtask

   task automatic do_op(input string tg, input logic st, input logic by, input logic se,
                        input logic [15:0] a, input logic [15:0] wd, input bit noise);
      int          acc, nwr;
      logic [15:0] a1, base;
      logic [7:0]  b;
      a1 = a + 16'd1;
      base = {a[15:1], 1'b0};
      if (!st) begin
         acc = (by || !a[0]) ? 1 : 2;
         nwr = 0;
         b = ref_mem[a];
         if (by) rdata_exp = se ? {{8{b[7]}}, b} : {8'h00, b};
         else    rdata_exp = {ref_mem[a1], ref_mem[a]};
      end else begin
         acc = by ? 2 : (a[0] ? 4 : 1);
         nwr = by ? 1 : (a[0] ? 2 : 1);
         ref_mem[a] = wd[7:0];
         if (!by) ref_mem[a1] = wd[15:8];
      end
      run_op(st, by, se, a, wd, noise);
      chk({tg, "/latency"}, lat, acc + 1);
      chk({tg, "/writes"}, we_cnt, nwr);
      chk({tg, "/mem_cycles"}, seq_n, acc);
      chk({tg, "/odd_addrm"}, odd_cnt, 0);
      chk({tg, "/busy"}, busy_bad, 0);
      chk({tg, "/rdata"}, bus.rdata, rdata_exp);
      for (int k = 0; k < 4; k++) begin
         logic [15:0] ma;
         ma = base + 16'(k);
         chk($sformatf("%s/mem%04h", tg, ma), mem[ma], ref_mem[ma]);
      end
   endtask

   initial begin
      bus.req = 1'b0; bus.is_store = 1'b0; bus.is_byte = 1'b0; bus.sign_ext = 1'b0;
      bus.addr = 16'h0000; bus.wdata = 16'h0000;
      #12;
      chk("rst/busy", bus.busy, 0);
      chk("rst/done", bus.done, 0);
      chk("rst/rdata", bus.rdata, 16'h0000);
      chk("rst/we", bus.we, 0);
      chk("rst/mem_alu", bus.mem_alu, 0);
      chk("rst/addrm", bus.addrm, 16'h0000);
      chk("rst/wmdata", bus.wmdata, 16'h0000);
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 64; i++) begin
         preload(16'(i), 8'($urandom));
         preload(16'hFFC0 + 16'(i), 8'($urandom));
      end

      // Scenario 1/2: aligned and unaligned word loads
      preload(16'h0010, 8'h34); preload(16'h0011, 8'h12);
      preload(16'h0012, 8'h78); preload(16'h0013, 8'h56);
      do_op("p1", 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0);
      chk("p1/addrm", seq_a[0], 16'h0010);
      chk("p1/value", bus.rdata, 16'h1234);
      do_op("p2", 1'b0, 1'b0, 1'b0, 16'h0011, 16'h0000, 1'b0);
      chk("p2/addrm0", seq_a[0], 16'h0010);
      chk("p2/addrm1", seq_a[1], 16'h0012);
      chk("p2/value", bus.rdata, 16'h7812);

      // Scenario 3: byte loads with and without sign extension
      preload(16'h00F0, 8'h55); preload(16'h00F1, 8'h9A);
      do_op("p3s", 1'b0, 1'b1, 1'b1, 16'h00F1, 16'h0000, 1'b0);
      chk("p3s/value", bus.rdata, 16'hFF9A);
      do_op("p3z", 1'b0, 1'b1, 1'b0, 16'h00F1, 16'h0000, 1'b0);
      chk("p3z/value", bus.rdata, 16'h009A);

      // Scenario 4: byte store read-modify-write
      do_op("p4", 1'b1, 1'b1, 1'b0, 16'h0011, 16'h00AB, 1'b0);
      chk("p4/addrm", seq_a[1], 16'h0010);
      chk("p4/wmdata", seq_w[1], 16'hAB34);
      chk("p4/m10", mem[16'h0010], 8'h34);
      chk("p4/m11", mem[16'h0011], 8'hAB);
      chk("p4/rdata_kept", bus.rdata, 16'h009A);

      // Scenario 5: unaligned word store wrapping past the top of memory
      preload(16'hFFFE, 8'h11); preload(16'h0000, 8'h33); preload(16'h0001, 8'h22);
      do_op("p5", 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hBEEF, 1'b0);
      chk("p5/a0", seq_a[0], 16'hFFFE);
      chk("p5/a1", seq_a[1], 16'hFFFE);
      chk("p5/a2", seq_a[2], 16'h0000);
      chk("p5/a3", seq_a[3], 16'h0000);
      chk("p5/w1", seq_w[1], 16'hEF11);
      chk("p5/w3", seq_w[3], 16'h22BE);
      chk("p5/mFFFF", mem[16'hFFFF], 8'hEF);
      chk("p5/m0000", mem[16'h0000], 8'hBE);
      chk("p5/mFFFE", mem[16'hFFFE], 8'h11);
      chk("p5/m0001", mem[16'h0001], 8'h22);

      // Scenario 6: asynchronous reset during the final write
      @(negedge clock);
      bus.req = 1'b1; bus.is_store = 1'b1; bus.is_byte = 1'b0; bus.sign_ext = 1'b0;
      bus.addr = 16'hFFFF; bus.wdata = 16'h1357;
      @(negedge clock);
      bus.req = 1'b0;
      repeat (3) @(negedge clock);
      chk("p6/in_wr_hi_we", bus.we, 1);
      chk("p6/in_wr_hi_addrm", bus.addrm, 16'h0000);
      #2 reset = 1'b1;
      #1;
      chk("p6/we_drop", bus.we, 0);
      chk("p6/busy_drop", bus.busy, 0);
      chk("p6/mem_alu_drop", bus.mem_alu, 0);
      done_cnt = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         if (bus.done) done_cnt++;
      end
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         if (bus.done || bus.busy) done_cnt++;
      end
      chk("p6/no_done", done_cnt, 0);
      chk("p6/mFFFF", mem[16'hFFFF], 8'h57);
      chk("p6/m0000", mem[16'h0000], 8'hBE);
      chk("p6/rdata_reset", bus.rdata, 16'h0000);
      ref_mem[16'hFFFF] = 8'h57;
      rdata_exp = 16'h0000;
      do_op("p6new", 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b0);
      chk("p6new/value", bus.rdata, 16'hBE57);

      // Randomized mix of loads and stores with req noise while busy
      for (int i = 0; i < 60; i++) begin
         int          r;
         logic [15:0] a;
         r = int'($urandom_range(0, 124));
         a = (r < 61) ? 16'(r) : (16'hFFC0 + 16'(r - 61));
         do_op($sformatf("rnd%0d", i), 1'($urandom), 1'($urandom), 1'($urandom),
               a, 16'($urandom), 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store initiator between the core datapath and the byte-addressed 64 KB data memory.
- The memory returns {mem[addr|1], mem[addr]} combinationally and writes both bytes of that pair on the clock edge when we=1.
- mem_lsu issues only even (aligned) addresses to the memory.
- Byte accesses and odd-address word accesses become multi-cycle read / read-modify-write sequences.

Parameters:
- AW, 16, address width; fixed at 16.
- DW, 16, data width; fixed at 16.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  1  access request; sampled only in IDLE
- is_store  in  1  1 = store, 0 = load
- is_byte  in  1  1 = byte access, 0 = word access
- sign_ext  in  1  byte loads: 1 = sign-extend, 0 = zero-extend
- addr  in  16  byte address
- wdata  in  16  store data; byte store uses wdata[7:0]
- busy  out  1  high while an access is in progress, including DONE
- done  out  1  one-cycle completion pulse
- rdata  out  16  load result; held until the next load completes
- addrm  out  16  memory address, always even
- wmdata  out  16  memory write data
- we  out  1  memory write enable
- mem_alu  out  1  high while a memory access state is active
- rmdata  in  16  memory read data (combinational from addrm)

Behaviour:
- Reset (async): state=IDLE; busy=0, done=0, rdata=0, we=0, mem_alu=0, addrm=0, wmdata=0.
- Acceptance: in IDLE, req=1 at an edge latches addr, wdata, is_store, is_byte and sign_ext. req is ignored in every other state.
- Decoded outputs: addrm, wmdata, we and mem_alu are decoded from state plus latched registers.
  - we=1 only in WR_LO and WR_HI.
  - mem_alu=1 in RD_LO, RD_HI, WR_LO and WR_HI.
- Address bases: A = {addr[15:1],0}; A2 = A+2, modulo 2^16 (so 0xFFFE wraps to 0x0000).
- States: IDLE, RD_LO, WR_LO, RD_HI, WR_HI, DONE. Each access state lasts exactly one cycle.
- Sequences:
  - Word load, even address: RD_LO. rdata <= rmdata.
  - Word load, odd address: RD_LO (lo <= rmdata[15:8]), then RD_HI at A2 (rdata <= {rmdata[7:0], lo}).
  - Byte load: RD_LO. The byte is rmdata[15:8] if addr[0]=1, else rmdata[7:0]. Extend per sign_ext.
  - Word store, even address: WR_LO, with wmdata = wdata.
  - Byte store: RD_LO latches the word into buf. WR_LO writes buf with the addressed byte replaced by wdata[7:0].
  - Word store, odd address:
    - RD_LO, then WR_LO writing {wdata[7:0], buf[7:0]} at A.
    - RD_HI at A2, then WR_HI writing {buf[15:8], wdata[15:8]} at A2.
- Completion: after the last access state, go to DONE. done=1 and busy=1 for that one cycle, then IDLE.
- Timing: busy rises the cycle after acceptance. Latency from the accept edge to done = access-state count + 1 cycles (2 to 5).
- Loads update rdata at the edge leaving their final RD state. Stores never modify rdata.
- Write scope: no write ever touches a byte other than the addressed one(s). Bytes not being stored are rewritten with the value just read.
- Reset mid-operation: we and mem_alu drop immediately and the state returns to IDLE. A write already committed on a prior edge stays; the remaining steps are abandoned with no done.
- Read timing: no read-during-write hazard. Every read state is separated from its write by a clock edge.

Test Plan:
1. Preload mem[0x10..0x13] = 34,12,78,56. Word load at 0x0010 -> addrm=0x0010 for 1 cycle; done 2 cycles after accept; rdata=0x1234.
2. Word load at 0x0011 -> addrm 0x0010 then 0x0012; done after 3 cycles; rdata=0x7812; we never high.
3. Preload mem[0xF1]=0x9A. Byte load at 0x00F1 with sign_ext=1 -> rdata=0xFF9A; repeat with sign_ext=0 -> 0x009A.
4. Byte store at 0x0011, wdata=0x00AB:
   - RD_LO, then WR_LO with addrm=0x0010 and wmdata=0xAB34; we high exactly 1 cycle.
   - Result: mem[0x10]=0x34, mem[0x11]=0xAB.
5. Word store at 0xFFFF, wdata=0xBEEF:
   - Address sequence 0xFFFE, 0xFFFE, 0x0000, 0x0000 (wrap).
   - Result: mem[0xFFFF]=0xEF, mem[0x0000]=0xBE; mem[0xFFFE] and mem[0x0001] unchanged; done after 5 cycles.
6. Assert reset asynchronously during WR_HI of scenario 5:
   - we=0 and busy=0 immediately; no done pulse.
   - mem[0xFFFF]=0xEF (committed earlier); mem[0x0000] unchanged.
   - A new req after reset release is accepted normally.
